sensor_axis_bridge: RTL and testbench

Parametrised camera-to-AXI4-Stream video bridge. Converts parallel sensor timing (pclk, data, frame-valid `fm`, line-valid `ln`) into an AXI4-Stream video master with a real output FIFO that honours `tready`. Generates a single-cycle `tlast` on each line's final pixel and `tuser` on each frame's first pixel. Sits between the sensor pins and the first video-processing core, which may stall.

---
 rtl/sensor_axis_bridge_if.sv | 14 +
 rtl/sensor_axis_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_sensor_axis_bridge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_axis_bridge_if.sv
// AXI4-Stream video channel driven by sensor_axis_bridge (master) toward the
// first video-processing core (slave).
interface sensor_axis_bridge_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/sensor_axis_bridge.sv
// Parallel camera timing (fm/ln/data) to AXI4-Stream video with a FWFT output FIFO.
// Define SENSOR_AXIS_DIMS_EN to add the line_pixels/frame_lines dimension counters.
module sensor_axis_bridge #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    data,
  input  logic                 fm,
  input  logic                 ln,
  sensor_axis_bridge_if.master m_axis_video,
  output logic                 overflow,
  output logic                 frame_drop
`ifdef SENSOR_AXIS_DIMS_EN
  ,
  output logic [15:0]          line_pixels,
  output logic [15:0]          frame_lines
`endif
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] data_q;
  logic              fm_q, fm_dly_q, ln_q;
  logic              pend_valid_q, pend_valid_d, pend_sof_q, pend_sof_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              sof_pend_q, sof_pend_d;
  logic              overflow_q, overflow_d, frame_drop_q, frame_drop_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     wr_entry, head;

  logic pv, fm_rise, fm_fall, full, pop, accept, drop, wr_en, sof_set;

  assign pv      = fm_q & ln_q;
  assign fm_rise = fm_q & ~fm_dly_q;
  assign fm_fall = ~fm_q & fm_dly_q;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = m_axis_video.tvalid & m_axis_video.tready;
  assign sof_set = sof_pend_q | fm_rise;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_sof_d   = pend_sof_q;
    sof_pend_d   = sof_pend_q;
    overflow_d   = overflow_q;
    frame_drop_d = 1'b0;
    wr_en        = 1'b0;
    drop         = 1'b0;
    wr_entry     = {pend_sof_q, ~pv, pend_data_q};

    case (state_q)
      IDLE:    accept = fm_rise;
      ACTIVE:  accept = 1'b1;
      default: accept = 1'b0;
    endcase

    if (accept) begin
      // Pending pixel commits once the following stage sample shows whether the line continues.
      if (pend_valid_q) begin
        if (full && !pop) drop = 1'b1;
        else              wr_en = 1'b1;
      end
      if (drop) begin
        pend_valid_d = 1'b0;
        overflow_d   = 1'b1;
        frame_drop_d = 1'b1;
      end else if (pv) begin
        pend_valid_d = 1'b1;
        pend_data_d  = data_q;
        pend_sof_d   = sof_set;
        sof_pend_d   = 1'b0;
      end else begin
        pend_valid_d = 1'b0;
        sof_pend_d   = sof_set;
      end
      // A drop on the fm-fall cycle goes straight to IDLE so the next frame is not lost.
      if (fm_fall)   state_d = IDLE;
      else if (drop) state_d = DROP;
      else           state_d = ACTIVE;
    end else begin
      pend_valid_d = 1'b0;
      if (state_q == DROP && fm_fall) state_d = IDLE;
    end
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // fm history resets high so a frame already in progress at reset release is not seen as a rise.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      fm_q         <= 1'b1;
      fm_dly_q     <= 1'b1;
      ln_q         <= 1'b0;
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_sof_q   <= 1'b0;
      sof_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      data_q       <= data;
      fm_q         <= fm;
      fm_dly_q     <= fm_q;
      ln_q         <= ln;
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_sof_q   <= pend_sof_d;
      sof_pend_q   <= sof_pend_d;
      overflow_q   <= overflow_d;
      frame_drop_q <= frame_drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head                = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign m_axis_video.tvalid = (cnt_q != '0);
  assign m_axis_video.tdata  = head[DATA_W-1:0];
  assign m_axis_video.tlast  = head[DATA_W];
  assign m_axis_video.tuser  = head[DATA_W+1];
  assign overflow            = overflow_q;
  assign frame_drop          = frame_drop_q;

`ifdef SENSOR_AXIS_DIMS_EN
  logic [15:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0] line_pixels_q, line_pixels_d, frame_lines_q, frame_lines_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_pixels_d = line_pixels_q;
    frame_lines_d = frame_lines_q;
    if (fm_rise) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end
    if (wr_en) begin
      if (!pv) begin
        line_pixels_d = sat_inc(pix_cnt_q);
        pix_cnt_d     = '0;
        line_cnt_d    = sat_inc(line_cnt_q);
      end else begin
        pix_cnt_d     = sat_inc(pix_cnt_q);
      end
    end
    if (state_q == ACTIVE && fm_fall && !drop) begin
      frame_lines_d = line_cnt_d;
      line_cnt_d    = '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_pixels_q <= '0;
      frame_lines_q <= '0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_pixels_q <= line_pixels_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign line_pixels = line_pixels_q;
  assign frame_lines = frame_lines_q;
`endif
endmodule

// File: tb/tb_sensor_axis_bridge.sv
// Directed bench for sensor_axis_bridge: frame-level beat model checked on every handshake.
module tb_sensor_axis_bridge;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  logic              pclk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              fm, ln;
  logic              overflow, frame_drop;
`ifdef SENSOR_AXIS_DIMS_EN
  logic [15:0]       line_pixels, frame_lines;
`endif

  sensor_axis_bridge_if #(.DATA_W(DATA_W)) axis ();

  sensor_axis_bridge #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .data         (data),
    .fm           (fm),
    .ln           (ln),
    .m_axis_video (axis),
    .overflow     (overflow),
    .frame_drop   (frame_drop)
`ifdef SENSOR_AXIS_DIMS_EN
    ,
    .line_pixels  (line_pixels),
    .frame_lines  (frame_lines)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              u;
    logic              l;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0;
  int unsigned beats_seen = 0, tuser_seen = 0, tlast_seen = 0, drop_pulses = 0;
  int unsigned first_valid_cyc = 0, pix0_cyc = 0;
  int unsigned ready_mode = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Expected beats for a w x h frame; a stalled FIFO keeps only the first `limit` pixels.
  task automatic push_frame(input int w, input int h, input int base, input int limit);
    int n = 0;
    beat_t b;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < limit) begin
          b.d = DATA_W'(base + n);
          b.u = (n == 0);
          b.l = (c == w - 1);
          exp_q.push_back(b);
        end
        n++;
      end
    end
  endtask

  task automatic drive_frame(input int w, input int h, input int base);
    int n = 0;
    fm = 1'b1; ln = 1'b0;
    tick(); tick();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        ln = 1'b1;
        data = DATA_W'(base + n);
        if (n == 0) pix0_cyc = cyc;
        n++;
        tick();
      end
      ln = 1'b0; data = '0;
      tick(); tick();
    end
    fm = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while ((axis.tvalid || exp_q.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check({name, "_drain_bound"}, 32'(k < 300), 1);
    check({name, "_model_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      #1;
      case (ready_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = (cyc % 3 == 0);
        default: axis.tready = 1'b0;
      endcase
    end
  end

  // Compare process: every accepted beat must match the head of the model queue.
  initial begin
    logic        stall_prev = 1'b0;
    logic        seen_valid = 1'b0;
    logic        ok;
    beat_t       prev, e;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (frame_drop) drop_pulses++;
        if (axis.tvalid && !seen_valid) begin
          seen_valid = 1'b1;
          first_valid_cyc = cyc;
        end
        if (stall_prev) begin
          check("stall_tdata", axis.tdata, prev.d);
          check("stall_tuser", axis.tuser, prev.u);
          check("stall_tlast", axis.tlast, prev.l);
        end
        if (axis.tvalid && axis.tready) begin
          ok = (exp_q.size() != 0);
          check("beat_expected", ok, 1);
          if (ok) begin
            e = exp_q.pop_front();
            check("tdata", axis.tdata, e.d);
            check("tuser", axis.tuser, e.u);
            check("tlast", axis.tlast, e.l);
          end
          beats_seen++;
          if (axis.tuser) tuser_seen++;
          if (axis.tlast) tlast_seen++;
        end
        stall_prev = axis.tvalid && !axis.tready;
        prev.d = axis.tdata;
        prev.u = axis.tuser;
        prev.l = axis.tlast;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int unsigned snap;
    rst_n = 1'b0; fm = 1'b0; ln = 1'b0; data = '0; ready_mode = 0;
    repeat (3) tick();
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_drop", frame_drop, 0);
`ifdef SENSOR_AXIS_DIMS_EN
    check("rst_line_pixels", line_pixels, 0);
    check("rst_frame_lines", frame_lines, 0);
`endif
    rst_n = 1'b1;
    repeat (3) tick();

    // 4x3 frame, always ready
    push_frame(4, 3, 8'h10, 1000);
    drive_frame(4, 3, 8'h10);
    drain("f4x3");
    check("first_tvalid_latency", first_valid_cyc - pix0_cyc, 3);
    check("f4x3_beats", beats_seen, 12);
    check("f4x3_tuser_count", tuser_seen, 1);
    check("f4x3_tlast_count", tlast_seen, 3);

    // same frame, ready one cycle in three
    ready_mode = 1;
    push_frame(4, 3, 8'h10, 1000);
    drive_frame(4, 3, 8'h10);
    ready_mode = 0;
    drain("f4x3_throttled");
    check("throttled_overflow", overflow, 0);
    check("throttled_beats", beats_seen, 24);

    // 40-pixel line into a stalled FIFO, then a whole frame afterwards
    ready_mode = 2;
    push_frame(40, 1, 8'h40, FIFO_DEPTH);
    drive_frame(40, 1, 8'h40);
    check("drop_overflow", overflow, 1);
    check("drop_pulse_count", drop_pulses, 1);
    check("drop_held_tvalid", axis.tvalid, 1);
    ready_mode = 0;
    drain("drop_line");
    check("drop_beats", beats_seen, 40);
    push_frame(4, 2, 8'hA0, 1000);
    drive_frame(4, 2, 8'hA0);
    drain("after_drop");
    check("overflow_sticky", overflow, 1);
    check("after_drop_tuser_count", tuser_seen, 4);

    // one-pixel lines
    push_frame(1, 2, 8'hC0, 1000);
    drive_frame(1, 2, 8'hC0);
    drain("one_pixel");
    check("one_pixel_tlast_count", tlast_seen, 3 + 3 + 0 + 2 + 2);

    // reset mid-line with data held in the FIFO
    ready_mode = 2;
    fm = 1'b1; ln = 1'b0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      ln = 1'b1; data = DATA_W'(8'h50 + i);
      tick();
    end
    check("pre_reset_tvalid", axis.tvalid, 1);
    rst_n = 1'b0;
    @(negedge pclk);
    check("reset_flush_tvalid", axis.tvalid, 0);
    check("reset_clears_overflow", overflow, 0);
    tick();
    ready_mode = 0;
    tick();
    rst_n = 1'b1;
    snap = beats_seen;
    for (int i = 0; i < 4; i++) begin
      data = DATA_W'(8'h60 + i);
      tick();
    end
    ln = 1'b0; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      ln = 1'b1; data = DATA_W'(8'h68 + i);
      tick();
    end
    ln = 1'b0; tick(); tick();
    fm = 1'b0;
    repeat (6) tick();
    check("partial_frame_ignored", beats_seen - snap, 0);
    push_frame(3, 2, 8'h70, 1000);
    drive_frame(3, 2, 8'h70);
    drain("post_reset");
    check("post_reset_beats", beats_seen - snap, 6);

`ifdef SENSOR_AXIS_DIMS_EN
    push_frame(5, 2, 8'h90, 1000);
    drive_frame(5, 2, 8'h90);
    drain("dims");
    check("line_pixels", line_pixels, 5);
    check("frame_lines", frame_lines, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
